// File: rtl/pong_pkg.sv
// Types and helpers shared by the paddle,
// score and collision blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } paddle_state_t;

  typedef logic signed [11:0] pos_t;

  // Saturate a signed row position into [0, hi].
  function automatic pos_t clamp_pos(
    input pos_t v,
    input pos_t hi
  );
    if (v < 12'sd0) return 12'sd0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// VGA display geometry shared by the
// PONG overlay chain.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

endpackage

// File: rtl/vga_if.sv
// Pixel stream bundle passed between
// overlay stages of the display chain.
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount,
    input vcount,
    input hsync,
    input vsync,
    input hblnk,
    input vblnk,
    input rgb
  );

  modport out (
    output hcount,
    output vcount,
    output hsync,
    output vsync,
    output hblnk,
    output vblnk,
    output rgb
  );

endinterface

// File: rtl/paddle_ctrl.sv
// Paddle motion: button sync, frame tick,
// hold-to-accelerate FSM and ball tracking.
module paddle_ctrl #(
  parameter int HEIGHT       = 100,
  parameter int Y_INIT       = 250,
  parameter int STEP_MIN     = 2,
  parameter int STEP_MAX     = 12,
  parameter int ACCEL_FRAMES = 4,
  parameter int AI_STEP      = 6,
  parameter int AI_DEADBAND  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        ai_en,
  input  logic [10:0] ball_y,
  input  logic        vblnk,
  output logic [10:0] y_position
);

  import pong_pkg::*;
  import vga_pkg::*;

  localparam pos_t Y_MAX =
    pos_t'(VER_PIXELS - HEIGHT);
  localparam pos_t HALF_H =
    pos_t'(HEIGHT / 2);
  localparam pos_t AI_S =
    pos_t'(AI_STEP);
  localparam pos_t AI_DB =
    pos_t'(AI_DEADBAND);
  localparam logic [7:0] S_MIN =
    8'(STEP_MIN);
  localparam logic [7:0] S_MAX =
    8'(STEP_MAX);
  localparam logic [7:0] H_LAST =
    8'(ACCEL_FRAMES - 1);
  localparam logic [10:0] Y_RST =
    11'(Y_INIT);

  logic          up_s1;
  logic          up_s2;
  logic          dn_s1;
  logic          dn_s2;
  logic          vblnk_q;
  logic          tick;
  logic          up_only;
  logic          dn_only;

  paddle_state_t state;
  paddle_state_t dir_nxt;
  logic [7:0]    step;
  logic [7:0]    hold_cnt;
  logic [7:0]    step_use;
  logic [7:0]    hold_nxt;

  pos_t          y_s;
  pos_t          btn_pos;
  pos_t          target;
  pos_t          diff;
  pos_t          adiff;
  pos_t          ai_mv;
  pos_t          ai_pos;
  pos_t          pos_nxt;

  assign tick    = vblnk & ~vblnk_q;
  assign up_only = up_s2 & ~dn_s2;
  assign dn_only = dn_s2 & ~up_s2;
  assign y_s     = $signed({1'b0, y_position});

  // Requested direction from the synced buttons.
  always_comb begin
    dir_nxt = IDLE;
    unique case (1'b1)
      up_only: dir_nxt = UP;
      dn_only: dir_nxt = DOWN;
      default: dir_nxt = IDLE;
    endcase
  end

  // Button move: a new direction restarts
  // at the minimum step.
  always_comb begin
    step_use = (dir_nxt == state) ?
               step : S_MIN;
    hold_nxt = (hold_cnt == H_LAST) ?
               8'd0 : hold_cnt + 8'd1;
    btn_pos  = y_s;
    unique case (dir_nxt)
      UP:
        btn_pos = y_s -
                  $signed({4'd0, step_use});
      DOWN:
        btn_pos = y_s +
                  $signed({4'd0, step_use});
      default:
        btn_pos = y_s;
    endcase
  end

  // Tracking move toward the centred ball,
  // limited by step size and deadband.
  always_comb begin
    target = clamp_pos(
      $signed({1'b0, ball_y}) - HALF_H,
      Y_MAX);
    diff   = target - y_s;
    adiff  = diff[11] ? -diff : diff;
    ai_mv  = (adiff > AI_S) ? AI_S : adiff;
    ai_pos = y_s;
    if (adiff > AI_DB) begin
      ai_pos = diff[11] ? y_s - ai_mv
                        : y_s + ai_mv;
    end
    pos_nxt = clamp_pos(
      ai_en ? ai_pos : btn_pos, Y_MAX);
  end

  // Two-flop button sync and vblank edge
  // history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_s1   <= 1'b0;
      up_s2   <= 1'b0;
      dn_s1   <= 1'b0;
      dn_s2   <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      up_s1   <= btn_up;
      up_s2   <= up_s1;
      dn_s1   <= btn_down;
      dn_s2   <= dn_s1;
      vblnk_q <= vblnk;
    end
  end

  // Once-per-frame FSM, acceleration and
  // position update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      step       <= S_MIN;
      hold_cnt   <= 8'd0;
      y_position <= Y_RST;
    end else if (tick) begin
      y_position <= 11'(pos_nxt);
      if (ai_en) begin
        state    <= IDLE;
        step     <= S_MIN;
        hold_cnt <= 8'd0;
      end else begin
        state <= dir_nxt;
        if (dir_nxt != IDLE) begin
          if (dir_nxt != state) begin
            step     <= S_MIN;
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_nxt;
            if (hold_nxt == H_LAST &&
                step < S_MAX) begin
              step <= step + 8'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/draw_paddle.sv
// Paddle overlay stage: draws one solid
// rectangle and exports its top row.
module draw_paddle #(
  parameter int          X_POS        = 30,
  parameter int          WIDTH        = 15,
  parameter int          HEIGHT       = 100,
  parameter logic [11:0] COLOR        = 12'hfff,
  parameter int          Y_INIT       = 250,
  parameter int          STEP_MIN     = 2,
  parameter int          STEP_MAX     = 12,
  parameter int          ACCEL_FRAMES = 4,
  parameter int          AI_STEP      = 6,
  parameter int          AI_DEADBAND  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        ai_en,
  input  logic [10:0] ball_y,
  output logic [10:0] y_position,
  vga_if.in           vga,
  vga_if.out          vga_out
);

  localparam logic [11:0] X_LO =
    12'(X_POS);
  localparam logic [11:0] X_HI =
    12'(X_POS + WIDTH);
  localparam logic [11:0] H_PX =
    12'(HEIGHT);

  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic [11:0] y_lo;
  logic [11:0] y_hi;
  logic        in_box;
  logic [11:0] rgb_nxt;

  paddle_ctrl #(
    .HEIGHT       (HEIGHT),
    .Y_INIT       (Y_INIT),
    .STEP_MIN     (STEP_MIN),
    .STEP_MAX     (STEP_MAX),
    .ACCEL_FRAMES (ACCEL_FRAMES),
    .AI_STEP      (AI_STEP),
    .AI_DEADBAND  (AI_DEADBAND)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .ai_en      (ai_en),
    .ball_y     (ball_y),
    .vblnk      (vga.vblnk),
    .y_position (y_position)
  );

  // Paddle hit test on the incoming
  // counters, widened to avoid overflow.
  always_comb begin
    h_ext   = {1'b0, vga.hcount};
    v_ext   = {1'b0, vga.vcount};
    y_lo    = {1'b0, y_position};
    y_hi    = y_lo + H_PX;
    in_box  = (h_ext >= X_LO) &&
              (h_ext <  X_HI) &&
              (v_ext >= y_lo) &&
              (v_ext <  y_hi);
    rgb_nxt = in_box ? COLOR : vga.rgb;
  end

  // One-cycle pipeline keeping colour and
  // timing fields aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= 12'd0;
    end else begin
      vga_out.hcount <= vga.hcount;
      vga_out.vcount <= vga.vcount;
      vga_out.hsync  <= vga.hsync;
      vga_out.vsync  <= vga.vsync;
      vga_out.hblnk  <= vga.hblnk;
      vga_out.vblnk  <= vga.vblnk;
      vga_out.rgb    <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_draw_paddle.sv
// Self-checking bench for draw_paddle:
// table vectors, directed sequences, random frames.
module tb_draw_paddle;

  localparam int VER   = 600;
  localparam int HGT   = 100;
  localparam int YMAX  = VER - HGT;
  localparam int XL    = 30;
  localparam int XW    = 15;
  localparam int SMIN  = 2;
  localparam int SMAX  = 12;
  localparam int ACC   = 4;
  localparam int AIS   = 6;
  localparam int DB    = 4;
  localparam int YINIT = 250;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up;
  logic        btn_down;
  logic        ai_en;
  logic [10:0] ball_y;
  logic [10:0] y_position;

  vga_if vga_in ();
  vga_if vga_o ();

  draw_paddle dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .ai_en      (ai_en),
    .ball_y     (ball_y),
    .y_position (y_position),
    .vga        (vga_in),
    .vga_out    (vga_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_y    = YINIT;
  int m_prev = 0;
  int m_n    = 0;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] rgb;
    logic [11:0] exp_rgb;
  } ovl_t;

  ovl_t tbl [8];

  task automatic check(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int clampi(
    input int v, input int lo, input int hi
  );
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [11:0] exp_pix(
    input int h, input int v,
    input logic [11:0] rgb
  );
    if (h >= XL && h < XL + XW &&
        v >= m_y && v < m_y + HGT)
      return 12'hfff;
    return rgb;
  endfunction

  task automatic model_reset();
    m_y    = YINIT;
    m_prev = 0;
    m_n    = 0;
  endtask

  // Frame-level rules: n-th held frame moves
  // by min(SMIN + (n-1)/ACC, SMAX).
  task automatic model_tick(
    input bit up, input bit dn,
    input bit ai, input int by
  );
    int t;
    int d;
    int s;
    int dir;
    if (ai) begin
      t = clampi(by - HGT / 2, 0, YMAX);
      d = t - m_y;
      if (d > DB)
        m_y = m_y + ((d < AIS) ? d : AIS);
      else if (d < -DB)
        m_y = m_y - ((-d < AIS) ? -d : AIS);
      m_prev = 0;
      m_n    = 0;
    end else begin
      dir = (up && !dn) ? 1 :
            (dn && !up) ? 2 : 0;
      if (dir == 0) begin
        m_n = 0;
      end else begin
        m_n = (dir == m_prev) ? m_n + 1 : 1;
        s = SMIN + (m_n - 1) / ACC;
        if (s > SMAX) s = SMAX;
        m_y = clampi((dir == 1) ? m_y - s
                                : m_y + s,
                     0, YMAX);
      end
      m_prev = dir;
    end
  endtask

  task automatic pix(
    input logic [10:0] h,
    input logic [10:0] v,
    input logic [11:0] rgb,
    input logic [11:0] exp,
    input string       nm
  );
    logic hs;
    logic vs;
    logic hb;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    hb = 1'($urandom_range(0, 1));
    vga_in.hcount = h;
    vga_in.vcount = v;
    vga_in.rgb    = rgb;
    vga_in.hsync  = hs;
    vga_in.vsync  = vs;
    vga_in.hblnk  = hb;
    vga_in.vblnk  = 1'b0;
    @(posedge clk);
    #1;
    check({nm, ".rgb"}, 64'(vga_o.rgb),
          64'(exp));
    check({nm, ".pass"},
          64'({vga_o.hcount, vga_o.vcount,
               vga_o.hsync, vga_o.vsync,
               vga_o.hblnk}),
          64'({h, v, hs, vs, hb}));
  endtask

  task automatic frame(
    input bit up, input bit dn,
    input bit ai, input int by,
    input int hi_cyc, input string nm
  );
    btn_up   = up;
    btn_down = dn;
    ai_en    = ai;
    ball_y   = 11'(by);
    repeat (4) @(posedge clk);
    #1;
    vga_in.vblnk = 1'b1;
    @(posedge clk);
    #1;
    check({nm, ".vbl"}, 64'(vga_o.vblnk),
          64'd1);
    repeat (hi_cyc - 1) @(posedge clk);
    #1;
    vga_in.vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_tick(up, dn, ai, by);
    check({nm, ".y"}, 64'(y_position),
          64'(m_y));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("reset.y", 64'(y_position),
          64'(YINIT));
  endtask

  initial begin
    tbl[0] = '{11'd30, 11'd250, 12'h0ab, 12'hfff};
    tbl[1] = '{11'd44, 11'd349, 12'h123, 12'hfff};
    tbl[2] = '{11'd45, 11'd300, 12'h456, 12'h456};
    tbl[3] = '{11'd30, 11'd350, 12'h789, 12'h789};
    tbl[4] = '{11'd29, 11'd250, 12'h0a5, 12'h0a5};
    tbl[5] = '{11'd30, 11'd249, 12'h111, 12'h111};
    tbl[6] = '{11'd37, 11'd300, 12'h000, 12'hfff};
    tbl[7] = '{11'd44, 11'd250, 12'h5a5, 12'hfff};

    rst           = 1'b1;
    btn_up        = 1'b0;
    btn_down      = 1'b0;
    ai_en         = 1'b0;
    ball_y        = 11'd0;
    vga_in.hcount = 11'd7;
    vga_in.vcount = 11'd9;
    vga_in.hsync  = 1'b1;
    vga_in.vsync  = 1'b1;
    vga_in.hblnk  = 1'b1;
    vga_in.vblnk  = 1'b0;
    vga_in.rgb    = 12'h5a5;
    repeat (3) @(posedge clk);
    #1;
    check("por.y", 64'(y_position),
          64'(YINIT));
    check("por.vga",
          64'({vga_o.hcount, vga_o.vcount,
               vga_o.hsync, vga_o.vsync,
               vga_o.hblnk, vga_o.vblnk,
               vga_o.rgb}),
          64'd0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++)
      pix(tbl[i].h, tbl[i].v, tbl[i].rgb,
          tbl[i].exp_rgb,
          $sformatf("ovl%0d", i));

    for (int i = 0; i < 12; i++)
      frame(1'b0, 1'b1, 1'b0, 0, 3,
            $sformatf("accel%0d", i));
    check("accel.final", 64'(y_position),
          64'd286);

    vga_in.hcount = 11'd100;
    vga_in.vcount = 11'd200;
    vga_in.rgb    = 12'habc;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid.y", 64'(y_position),
          64'(YINIT));
    check("rst_mid.vga",
          64'({vga_o.hcount, vga_o.vcount,
               vga_o.hsync, vga_o.vsync,
               vga_o.hblnk, vga_o.vblnk,
               vga_o.rgb}),
          64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    pix(11'd300, 11'd40, 12'h3c3, 12'h3c3,
        "rst_rel");

    frame(1'b0, 1'b1, 1'b0, 0, 200, "long_vbl");
    check("long_vbl.once", 64'(y_position),
          64'd252);
    for (int i = 0; i < 4; i++)
      frame(1'b0, 1'b1, 1'b0, 0, 2,
            $sformatf("pre_rev%0d", i));
    frame(1'b1, 1'b0, 1'b0, 0, 2, "reverse");
    check("reverse.min", 64'(y_position),
          64'd259);

    btn_up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_up = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    frame(1'b0, 1'b0, 1'b0, 0, 2, "pulse");
    check("pulse.still", 64'(y_position),
          64'd259);

    do_reset();
    for (int i = 0; i < 20; i++)
      frame(1'b0, 1'b0, 1'b1, 400, 2,
            $sformatf("ai400_%0d", i));
    check("ai400.final", 64'(y_position),
          64'd346);
    for (int i = 0; i < 65; i++)
      frame(1'b1, 1'b0, 1'b1, 20, 2,
            $sformatf("ai20_%0d", i));
    check("ai20.final", 64'(y_position),
          64'd4);

    for (int i = 0; i < 3; i++)
      frame(1'b1, 1'b0, 1'b0, 0, 2,
            $sformatf("top%0d", i));
    check("top.clamp", 64'(y_position),
          64'd0);
    frame(1'b0, 1'b1, 1'b0, 0, 2, "top_rev");
    check("top_rev.y", 64'(y_position),
          64'd2);
    frame(1'b1, 1'b1, 1'b0, 0, 2, "both");
    check("both.y", 64'(y_position),
          64'd2);

    for (int i = 0; i < 90; i++)
      frame(1'b0, 1'b0, 1'b1, 2000, 1,
            $sformatf("ai_bot%0d", i));
    check("ai_bot.final", 64'(y_position),
          64'd500);
    frame(1'b0, 1'b1, 1'b0, 0, 2, "bot");
    check("bot.clamp", 64'(y_position),
          64'd500);

    for (int i = 0; i < 40; i++) begin
      frame(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 2047)),
            int'($urandom_range(1, 6)),
            $sformatf("rnd%0d", i));
      for (int k = 0; k < 3; k++) begin
        int h;
        int v;
        logic [11:0] c;
        h = int'($urandom_range(20, 55));
        v = m_y +
            int'($urandom_range(0, 120)) - 10;
        if (v < 0) v = 0;
        c = 12'($urandom_range(0, 4095));
        pix(11'(h), 11'(v), c,
            exp_pix(h, v, c),
            $sformatf("rpx%0d_%0d", i, k));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
